// File: rtl/pong_pkg.sv
// Shared Pong geometry constants and types, used by the paddle controllers and the pixel generator.
package pong_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int PADDLE_H = 72;
   localparam int PADDLE_W = 8;
   localparam int STEP     = 4;
   localparam int COORD_W  = 10;

   typedef enum logic [1:0] {
      MV_HOLD = 2'd0,
      MV_UP   = 2'd1,
      MV_DOWN = 2'd2
   } move_e;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Per-paddle signal bundle: frame pulse and raw buttons in, position and status out.
interface paddle_ctrl_if
   import pong_pkg::*;
();
   logic               frame_tick;
   logic               btn_up;
   logic               btn_down;
   logic [COORD_W-1:0] paddle_y;
   logic               up_db;
   logic               down_db;
   logic               at_top;
   logic               at_bottom;

   modport master (
      output frame_tick, btn_up, btn_down,
      input  paddle_y, up_db, down_db, at_top, at_bottom
   );

   modport slave (
      input  frame_tick, btn_up, btn_down,
      output paddle_y, up_db, down_db, at_top, at_bottom
   );
endinterface

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a stability counter; the output only follows
// the input after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             db_q;
   logic [CNT_W-1:0] cnt_q;

   // Synchronize, then flip the debounced state on the last cycle of a full disagreement run
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         if (sync2_q == db_q) begin
            cnt_q <= {CNT_W{1'b0}};
         end else if (cnt_q == CNT_LAST) begin
            db_q  <= sync2_q;
            cnt_q <= {CNT_W{1'b0}};
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign dout = db_q;
endmodule

// File: rtl/paddle_ctrl.sv
// Debounced up/down buttons move a clamped paddle top line by STEP once per frame_tick.
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int INIT_Y          = 204
) (
   input  logic           clk,
   input  logic           rst,
   paddle_ctrl_if.slave   pif
);
   localparam logic [COORD_W-1:0] Y_MAX_C  = COORD_W'(SCREEN_H - PADDLE_H);
   localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
   localparam logic [COORD_W-1:0] INIT_Y_C = COORD_W'(INIT_Y);

   logic               up_db_s;
   logic               down_db_s;
   move_e              move_s;
   logic [COORD_W:0]   y_sum_s;
   logic [COORD_W-1:0] y_q;
   logic [COORD_W-1:0] y_d;

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk  (clk),
      .rst  (rst),
      .din  (pif.btn_up),
      .dout (up_db_s)
   );

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk  (clk),
      .rst  (rst),
      .din  (pif.btn_down),
      .dout (down_db_s)
   );

   // Next position: conflicting or idle buttons hold; moves saturate at either screen edge
   always_comb begin
      move_s  = MV_HOLD;
      y_sum_s = {1'b0, y_q} + {1'b0, STEP_C};
      y_d     = y_q;
      if (up_db_s && !down_db_s) begin
         move_s = MV_UP;
      end else if (down_db_s && !up_db_s) begin
         move_s = MV_DOWN;
      end else begin
         move_s = MV_HOLD;
      end
      if (pif.frame_tick) begin
         case (move_s)
            MV_UP:   y_d = (y_q >= STEP_C) ? (y_q - STEP_C) : {COORD_W{1'b0}};
            MV_DOWN: y_d = (y_sum_s <= {1'b0, Y_MAX_C}) ? y_sum_s[COORD_W-1:0] : Y_MAX_C;
            default: y_d = y_q;
         endcase
      end else begin
         y_d = y_q;
      end
   end

   // Position register; reset wins over a coincident frame_tick
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q <= INIT_Y_C;
      end else begin
         y_q <= y_d;
      end
   end

   assign pif.paddle_y  = y_q;
   assign pif.up_db     = up_db_s;
   assign pif.down_db   = down_db_s;
   assign pif.at_top    = (y_q == {COORD_W{1'b0}});
   assign pif.at_bottom = (y_q == Y_MAX_C);
endmodule
